sme_sbox_seq: RTL and testbench
===============================

# sme_sbox_seq

Sequencer for the masked S-box middle layer (`sme_sbox_inv_mid`) in the SME datapath. It accepts one S-box operation at a time over a valid/ready handshake and admits it only when a fresh randomness word is available. It drives the layer's `en`, `flush` and `rng` inputs for exactly the layer latency, returns completion over a second valid/ready handshake, and then flushes the layer so no share residue persists between operations. Aborts and completed-operation statistics are also handled here.

## Interface
Parameters:
- `SMAX`, 2: number of shares per bit.
- `AND_GATES`, 34: DOM AND gates in the controlled layer.
- `LAT`, 2: register stages of the controlled layer; legal range 1..15.
- `RW` (localparam): `AND_GATES*SMAX*(SMAX-1)/2 - 1`, MSB index of the guard-randomness bus.

Ports:
- `g_clk` in 1: global clock, posedge.
- `g_resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: an operation is requested; operands are already on the layer `x` inputs.
- `req_ready` out 1: operation accepted this cycle if `req_valid` is also high.
- `rng_valid` in 1: `rng_in` holds a fresh, unused randomness word.
- `rng_in` in RW+1: randomness word from the PRNG.
- `rng_ready` out 1: `rng_in` consumed this cycle.
- `flush_req` in 1: abort any operation and flush the layer.
- `rsp_valid` out 1: layer `y` outputs are valid.
- `rsp_ready` in 1: consumer has taken the result.
- `mid_en` out 1: drives the layer `en`.
- `mid_flush` out 1: drives the layer `flush`.
- `mid_rng` out RW+1: drives the layer `rng`.
- `busy` out 1: state is not IDLE.
- `ops_done` out 16: count of completed responses.

## Operation
- States: IDLE, RUN, DONE, FLUSH. Reset state is IDLE.
- `req_ready = (state==IDLE) && rng_valid && !flush_req`, combinational.
- `rng_ready = req_valid && req_ready`. This is also the accept condition.
- Outputs decoded from state: `mid_en = (state==RUN)`, `rsp_valid = (state==DONE)`, `mid_flush = (state==FLUSH)`, `busy = (state!=IDLE)`.
- Transitions:
  - IDLE → RUN on accept. At the same edge, `mid_rng <= rng_in` and `cnt <= LAT-1`.
  - IDLE → FLUSH if `flush_req` is high.
  - RUN: `cnt` decrements each edge. RUN → DONE at the edge where `cnt==0`.
  - DONE: holds until `rsp_ready`. On `rsp_valid && rsp_ready`, DONE → FLUSH and `ops_done` increments.
  - FLUSH → IDLE unconditionally after one cycle. At that edge `mid_rng <= 0`.
- `flush_req` in RUN or DONE forces the next state to FLUSH and has priority over all other transitions.
  - No response is produced for an aborted RUN.
  - If `flush_req` and `rsp_ready` are both high in DONE, the response completes and `ops_done` increments. Next state is FLUSH either way.
- `flush_req` held high in FLUSH keeps the state in FLUSH, so `mid_flush` stays high.
- `mid_rng` is loaded only at accept and stays stable through RUN and DONE. No randomness word is ever reused across operations.
- `ops_done` wraps from 0xFFFF to 0x0000. It is not cleared by `flush_req`.

## Timing
- Reset values while `g_resetn` is low: state IDLE, `cnt=0`, `mid_rng=0`, `ops_done=0`.
  - So `mid_en`, `mid_flush`, `rsp_valid` and `busy` are all 0.
  - `req_ready` and `rng_ready` follow their combinational equations.
- Reset asserted mid-operation returns to IDLE immediately. No flush cycle is generated.
- Accept at edge E0:
  - `mid_en` is high in cycles E0+1 .. E0+LAT (exactly LAT cycles).
  - `rsp_valid` first goes high in cycle E0+LAT+1.
- Response handshake at edge Er: `mid_flush` is high for cycle Er+1, and IDLE is reached at Er+2.
- Minimum initiation interval is LAT+3 cycles, with back-to-back `rsp_ready` and `rng_valid`.
- `rng_valid` low in IDLE stalls acceptance. `req_ready` stays 0 and no state changes.

## Test plan
- Basic op (LAT=2): `rng_valid=1`, `rng_in=0x5A…`, `req_valid` pulse at E0, `rsp_ready=1`.
  - `mid_en` high in cycles 1–2, `rsp_valid` in cycle 3, `mid_flush` in cycle 4, IDLE in cycle 5.
  - `mid_rng` equals 0x5A… in cycles 1–4, then 0. `ops_done=1`.
- Randomness starvation: `req_valid=1`, `rng_valid=0` for 5 cycles, then 1.
  - `req_ready` and `rng_ready` stay 0 and state stays IDLE for those 5 cycles.
  - Accept happens in cycle 6.
- Backpressure: `rsp_ready=0` for 4 cycles in DONE.
  - `rsp_valid` is held and `mid_en=0`.
  - `mid_rng` stays stable throughout; FLUSH follows the handshake.
- Abort: `flush_req` asserted in the second RUN cycle.
  - `rsp_valid` never asserts, `mid_flush` is high for one cycle, then IDLE.
  - `ops_done` is unchanged.
- Simultaneous `flush_req` and `rsp_ready` in DONE: `ops_done` increments once, and FLUSH follows.
- Wrap and reset: preload via 65,535 ops (or force), then complete one more so `ops_done` reads 0x0000.
  - Assert `g_resetn=0` mid-RUN: all outputs go to their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sme_sbox_seq.sv
// Sequencer for the masked S-box middle layer: gates each operation on a fresh
// randomness word, runs the layer for LAT cycles, hands back the result, then flushes.
module sme_sbox_seq #(
   parameter  int SMAX      = 2,
   parameter  int AND_GATES = 34,
   parameter  int LAT       = 2,
   localparam int RW        = AND_GATES*SMAX*(SMAX-1)/2 - 1
) (
   input  logic          g_clk,
   input  logic          g_resetn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          rng_valid,
   input  logic [RW:0]   rng_in,
   output logic          rng_ready,
   input  logic          flush_req,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          mid_en,
   output logic          mid_flush,
   output logic [RW:0]   mid_rng,
   output logic          busy,
   output logic [15:0]   ops_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_nxt;
   logic [3:0]  r_cnt;
   logic [RW:0] r_mid_rng;
   logic [15:0] r_ops_done;
   logic        w_accept;
   logic        w_rsp_hs;

   assign req_ready = (r_state == S_IDLE) && rng_valid && !flush_req;
   assign w_accept  = req_valid && req_ready;
   assign rng_ready = w_accept;
   // A response completes even when an abort arrives in the same DONE cycle.
   assign w_rsp_hs  = (r_state == S_DONE) && rsp_ready;

   assign mid_en    = (r_state == S_RUN);
   assign rsp_valid = (r_state == S_DONE);
   assign mid_flush = (r_state == S_FLUSH);
   assign busy      = (r_state != S_IDLE);
   assign mid_rng   = r_mid_rng;
   assign ops_done  = r_ops_done;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (flush_req) w_nxt = S_FLUSH;
                  else if (w_accept) w_nxt = S_RUN;
         S_RUN:   if (flush_req) w_nxt = S_FLUSH;
                  else if (r_cnt == 4'd0) w_nxt = S_DONE;
         S_DONE:  if (flush_req || rsp_ready) w_nxt = S_FLUSH;
         S_FLUSH: if (!flush_req) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_mid_rng  <= '0;
         r_ops_done <= 16'd0;
      end else begin
         r_state <= w_nxt;
         if (w_accept)
            r_cnt <= CNT_INIT;
         else if (r_state == S_RUN && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
         // Word is cleared on leaving FLUSH so no share mask survives into the next op.
         if (w_accept)
            r_mid_rng <= rng_in;
         else if (r_state == S_FLUSH && w_nxt == S_IDLE)
            r_mid_rng <= '0;
         if (w_rsp_hs)
            r_ops_done <= r_ops_done + 16'd1;
      end
   end

endmodule

// File: tb/tb_sme_sbox_seq.sv
// Self-checking bench for sme_sbox_seq: table of operations plus hand-written
// corner sequences, with a scoreboard of randomness words checked at each response.
module tb_sme_sbox_seq;

   localparam int LAT = 2;
   localparam int RW  = 33;

   logic          g_clk = 1'b0;
   logic          g_resetn;
   logic          req_valid, req_ready;
   logic          rng_valid, rng_ready;
   logic [RW:0]   rng_in;
   logic          flush_req;
   logic          rsp_valid, rsp_ready;
   logic          mid_en, mid_flush, busy;
   logic [RW:0]   mid_rng;
   logic [15:0]   ops_done;

   sme_sbox_seq #(.SMAX(2), .AND_GATES(34), .LAT(LAT)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .rng_valid(rng_valid), .rng_in(rng_in), .rng_ready(rng_ready),
      .flush_req(flush_req),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .mid_en(mid_en), .mid_flush(mid_flush), .mid_rng(mid_rng),
      .busy(busy), .ops_done(ops_done)
   );

   always #5 g_clk = ~g_clk;

   typedef struct {
      logic [RW:0] rng;
      int          bp;    // cycles of rsp_ready low in DONE
      int          mode;  // 0 normal, 1 abort in second RUN cycle, 2 flush_req with rsp_ready
   } vec_t;

   vec_t        vecs[5];
   logic [RW:0] sb_q[$];
   logic [15:0] exp_ops;
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   // Scoreboard: the word latched at accept must be on mid_rng at the response handshake.
   always @(negedge g_clk) begin
      #2;
      if (g_resetn && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) chk("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
         else chk("sb_rsp_rng", 64'(mid_rng), 64'(sb_q.pop_front()));
      end
   end

   task automatic idle_inputs();
      req_valid = 1'b0; rng_valid = 1'b0; rsp_ready = 1'b0; flush_req = 1'b0;
   endtask

   // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d_", idx);
      rng_in = v.rng; rng_valid = 1'b1; req_valid = 1'b1; rsp_ready = 1'b0; flush_req = 1'b0;
      #1;
      chk({p, "req_ready"}, 64'(req_ready), 64'd1);
      chk({p, "rng_ready"}, 64'(rng_ready), 64'd1);
      sb_q.push_back(v.rng);
      @(negedge g_clk);
      req_valid = 1'b0; rng_in = ~v.rng;
      for (int c = 1; c <= LAT; c++) begin
         chk({p, "run_en"}, 64'(mid_en), 64'd1);
         chk({p, "run_rsp"}, 64'(rsp_valid), 64'd0);
         chk({p, "run_rng"}, 64'(mid_rng), 64'(v.rng));
         if (v.mode == 1 && c == 2) begin
            flush_req = 1'b1;
            @(negedge g_clk);
            flush_req = 1'b0;
            chk({p, "abort_flush"}, 64'(mid_flush), 64'd1);
            chk({p, "abort_rsp"}, 64'(rsp_valid), 64'd0);
            chk({p, "abort_en"}, 64'(mid_en), 64'd0);
            @(negedge g_clk);
            chk({p, "abort_idle"}, 64'(busy), 64'd0);
            chk({p, "abort_rsp2"}, 64'(rsp_valid), 64'd0);
            chk({p, "abort_rng0"}, 64'(mid_rng), 64'd0);
            chk({p, "abort_ops"}, 64'(ops_done), 64'(exp_ops));
            void'(sb_q.pop_back());
            return;
         end
         @(negedge g_clk);
      end
      chk({p, "done_rsp"}, 64'(rsp_valid), 64'd1);
      chk({p, "done_en"}, 64'(mid_en), 64'd0);
      for (int b = 0; b < v.bp; b++) begin
         @(negedge g_clk);
         chk({p, "bp_rsp"}, 64'(rsp_valid), 64'd1);
         chk({p, "bp_en"}, 64'(mid_en), 64'd0);
         chk({p, "bp_rng"}, 64'(mid_rng), 64'(v.rng));
         chk({p, "bp_ops"}, 64'(ops_done), 64'(exp_ops));
      end
      rsp_ready = 1'b1;
      if (v.mode == 2) flush_req = 1'b1;
      exp_ops = exp_ops + 16'd1;
      @(negedge g_clk);
      rsp_ready = 1'b0; flush_req = 1'b0;
      chk({p, "fl_flush"}, 64'(mid_flush), 64'd1);
      chk({p, "fl_rsp"}, 64'(rsp_valid), 64'd0);
      chk({p, "fl_ops"}, 64'(ops_done), 64'(exp_ops));
      chk({p, "fl_rng"}, 64'(mid_rng), 64'(v.rng));
      @(negedge g_clk);
      chk({p, "end_busy"}, 64'(busy), 64'd0);
      chk({p, "end_flush"}, 64'(mid_flush), 64'd0);
      chk({p, "end_rng0"}, 64'(mid_rng), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rng: 34'h1_5A5A_5A5A, bp: 0, mode: 0};
      vecs[1] = '{rng: 34'h3_FFFF_FFFF, bp: 4, mode: 0};
      vecs[2] = '{rng: 34'h0_1234_5678, bp: 0, mode: 1};
      vecs[3] = '{rng: 34'h2_DEAD_BEEF, bp: 2, mode: 2};
      vecs[4] = '{rng: 34'h0_0000_0001, bp: 1, mode: 0};
      exp_ops = 16'd0;

      idle_inputs();
      rng_in = '0;
      g_resetn = 1'b0;
      rng_valid = 1'b1;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_en", 64'(mid_en), 64'd0);
      chk("rst_flush", 64'(mid_flush), 64'd0);
      chk("rst_rsp", 64'(rsp_valid), 64'd0);
      chk("rst_rng", 64'(mid_rng), 64'd0);
      chk("rst_ops", 64'(ops_done), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rng_ready", 64'(rng_ready), 64'd0);
      repeat (2) @(negedge g_clk);
      g_resetn = 1'b1;
      rng_valid = 1'b0;
      @(negedge g_clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Randomness starvation holds off acceptance.
      req_valid = 1'b1; rng_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("starve_req_ready", 64'(req_ready), 64'd0);
         chk("starve_rng_ready", 64'(rng_ready), 64'd0);
         chk("starve_busy", 64'(busy), 64'd0);
         @(negedge g_clk);
      end
      run_vec(vecs[0], 5);

      // flush_req in IDLE enters FLUSH and holds there while asserted.
      flush_req = 1'b1; rng_valid = 1'b1; req_valid = 1'b1;
      #1;
      chk("idlefl_req_ready", 64'(req_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge g_clk);
         chk("idlefl_flush", 64'(mid_flush), 64'd1);
         chk("idlefl_ops", 64'(ops_done), 64'(exp_ops));
      end
      idle_inputs();
      @(negedge g_clk);
      chk("idlefl_exit", 64'(busy), 64'd0);

      // Wrap: preload the counter to its maximum, then complete one op.
      force dut.r_ops_done = 16'hFFFF;
      #1;
      release dut.r_ops_done;
      exp_ops = 16'hFFFF;
      chk("wrap_preload", 64'(ops_done), 64'hFFFF);
      @(negedge g_clk);
      run_vec(vecs[4], 6);
      chk("wrap_zero", 64'(ops_done), 64'd0);

      // Asynchronous reset in the middle of RUN.
      rng_in = 34'h1_0F0F_0F0F; rng_valid = 1'b1; req_valid = 1'b1;
      @(negedge g_clk);
      idle_inputs();
      chk("arst_pre_en", 64'(mid_en), 64'd1);
      #2 g_resetn = 1'b0;
      #1;
      chk("arst_en", 64'(mid_en), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_rng", 64'(mid_rng), 64'd0);
      chk("arst_flush", 64'(mid_flush), 64'd0);
      chk("arst_rsp", 64'(rsp_valid), 64'd0);
      @(negedge g_clk);
      g_resetn = 1'b1;
      exp_ops = 16'd0;
      @(negedge g_clk);
      chk("arst_idle_after", 64'(busy), 64'd0);
      run_vec(vecs[1], 7);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
